act_buf_pingpong_ctrl: RTL and testbench
========================================

ACT_BUF_PINGPONG_CTRL -- requirements
Module: act_buf_pingpong_ctrl

Interface
REQ-001 AWIDTH, 7, word address width within one bank; physical buffer address is AWIDTH+1 bits (MSB = bank select).
REQ-002 ap_clk  input  1  single clock; all state updates on rising edge.
REQ-003 ap_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wr_req  input  1  activation writer requests a bank to fill; level, held until wr_grant.
REQ-005 wr_grant  output  1  writer owns bank wr_bank; level, high from grant until the cycle after wr_done.
REQ-006 wr_bank  output  1  bank index currently assigned to writer.
REQ-007 wr_done  input  1  one-cycle pulse: writer finished filling owned bank.
REQ-008 rd_req  input  1  PE requests a full bank to consume; level, held until rd_grant.
REQ-009 rd_grant  output  1  PE owns bank rd_bank; level, high from grant until the cycle after rd_done.
REQ-010 rd_bank  output  1  bank index currently assigned to PE.
REQ-011 rd_done  input  1  one-cycle pulse: PE finished consuming owned bank.
REQ-012 wr_addr_i / wr_addr_o  input AWIDTH / output AWIDTH+1  writer local address in; physical address out = {wr_bank, wr_addr_i}, combinational.
REQ-013 rd_addr_i / rd_addr_o  input AWIDTH / output AWIDTH+1  PE local address in; physical address out = {rd_bank, rd_addr_i}, combinational.
REQ-014 bank_full  output 2  bit n high when bank n is FULL or DRAINING.
REQ-015 proto_err  output 1  sticky protocol-violation flag.

Function
REQ-016 Each bank SHALL hold one of four states: EMPTY, FILLING, FULL, DRAINING.
REQ-017 Writer FSM SHALL have states W_IDLE, W_OWN; reader FSM SHALL have states R_IDLE, R_OWN.
REQ-018 Pointers wr_ptr and rd_ptr (1 bit each) SHALL select the next bank for writer and reader; wr_bank = wr_ptr, rd_bank = rd_ptr.
REQ-019 W_IDLE and wr_req and bank[wr_ptr]==EMPTY at edge: next cycle wr_grant=1, bank[wr_ptr]=FILLING, FSM=W_OWN (grant latency 1 cycle).
REQ-020 W_OWN and wr_done: next cycle bank[wr_ptr]=FULL, wr_ptr toggles, wr_grant=0, FSM=W_IDLE.
REQ-021 R_IDLE and rd_req and bank[rd_ptr]==FULL at edge: next cycle rd_grant=1, bank[rd_ptr]=DRAINING, FSM=R_OWN.
REQ-022 R_OWN and rd_done: next cycle bank[rd_ptr]=EMPTY, rd_ptr toggles, rd_grant=0, FSM=R_IDLE.
REQ-023 Grant decisions SHALL use registered bank states only; a bank freed/filled at edge k SHALL be grantable no earlier than edge k+1 (no same-cycle bypass).
REQ-024 Request while target bank is not grantable SHALL stall (no grant, no error) until bank becomes EMPTY/FULL respectively.
REQ-025 wr_done and rd_done in the same cycle on different banks SHALL both take effect.
REQ-026 wr_done while W_IDLE, or rd_done while R_IDLE, SHALL be ignored for state and SHALL set proto_err.
REQ-027 proto_err SHALL clear only on reset.
REQ-028 Writer and reader SHALL never be granted the same bank simultaneously; wr_grant&rd_grant implies wr_bank!=rd_bank.
REQ-029 wr_req/rd_req held high after done SHALL be treated as a new request evaluated from the idle state one cycle later.

Reset
REQ-030 ap_rst_n low SHALL immediately force: both banks EMPTY, wr_ptr=rd_ptr=0, FSMs idle, wr_grant=rd_grant=0, bank_full=2'b00, proto_err=0; wr_bank=rd_bank=0.
REQ-031 Reset asserted mid-transfer SHALL abandon ownership; buffer contents are not valid after reset.
REQ-032 After reset release, first wr_req SHALL be granted bank 0 one cycle later.

Verification
REQ-033 Basic: reset, wr_req -> wr_grant=1 next cycle, wr_bank=0; wr_addr_i=5 -> wr_addr_o=0x005; wr_done -> bank_full=01, wr_grant=0.
REQ-034 Ping-pong: fill bank0, rd_req -> rd_grant, rd_bank=0, rd_addr_i=3 -> rd_addr_o=0x003; concurrently wr_req -> wr_bank=1, wr_addr_i=3 -> wr_addr_o=0x083.
REQ-035 Full stall: fill bank0 and bank1 with no reads, third wr_req -> wr_grant stays 0; rd_done on bank0 -> wr_grant=1, wr_bank=0 two cycles after rd_done.
REQ-036 Empty stall: rd_req after reset -> rd_grant=0 indefinitely, proto_err=0; wr_done on bank0 -> rd_grant=1 two cycles later.
REQ-037 Errors/reset: wr_done pulse while W_IDLE -> proto_err=1, bank_full unchanged; assert ap_rst_n=0 mid-read -> all outputs zero asynchronously, proto_err=0.

Source files
------------

// File: rtl/act_buf_pingpong_ctrl.sv
// Ping-pong activation buffer controller: two banks handed between
// an activation writer and a PE reader with strict bank ownership.
module act_buf_pingpong_ctrl #(
  parameter int AWIDTH = 7
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              wr_req,
  output logic              wr_grant,
  output logic              wr_bank,
  input  logic              wr_done,
  input  logic              rd_req,
  output logic              rd_grant,
  output logic              rd_bank,
  input  logic              rd_done,
  input  logic [AWIDTH-1:0] wr_addr_i,
  output logic [AWIDTH:0]   wr_addr_o,
  input  logic [AWIDTH-1:0] rd_addr_i,
  output logic [AWIDTH:0]   rd_addr_o,
  output logic [1:0]        bank_full,
  output logic              proto_err
);

  localparam logic [1:0] B_EMPTY    = 2'b00;
  localparam logic [1:0] B_FILLING  = 2'b01;
  localparam logic [1:0] B_FULL     = 2'b10;
  localparam logic [1:0] B_DRAINING = 2'b11;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_OWN  = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_OWN  = 1'b1;

  logic [1:0][1:0] r_bank_st;
  logic [1:0][1:0] w_bank_nx;
  logic [0:0]      r_wr_st;
  logic [0:0]      r_rd_st;
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic            r_proto_err;

  logic w_wr_take;
  logic w_wr_fin;
  logic w_rd_take;
  logic w_rd_fin;
  logic w_err;

  // Grants look only at registered bank state, so a bank released
  // on one edge is first grantable on the following edge.
  assign w_wr_take = (r_wr_st == W_IDLE) && wr_req
                  && (r_bank_st[r_wr_ptr] == B_EMPTY);
  assign w_wr_fin  = (r_wr_st == W_OWN) && wr_done;
  assign w_rd_take = (r_rd_st == R_IDLE) && rd_req
                  && (r_bank_st[r_rd_ptr] == B_FULL);
  assign w_rd_fin  = (r_rd_st == R_OWN) && rd_done;

  assign w_err = (wr_done && (r_wr_st == W_IDLE))
              || (rd_done && (r_rd_st == R_IDLE));

  // Events on one edge always target distinct banks, since each
  // requires a different current state of its bank.
  always_comb begin
    w_bank_nx = r_bank_st;
    if (w_wr_take) w_bank_nx[r_wr_ptr] = B_FILLING;
    if (w_wr_fin)  w_bank_nx[r_wr_ptr] = B_FULL;
    if (w_rd_take) w_bank_nx[r_rd_ptr] = B_DRAINING;
    if (w_rd_fin)  w_bank_nx[r_rd_ptr] = B_EMPTY;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_bank_st <= {B_EMPTY, B_EMPTY};
    end else begin
      r_bank_st <= w_bank_nx;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wr_st  <= W_IDLE;
      r_wr_ptr <= 1'b0;
    end else begin
      unique case (r_wr_st)
        W_IDLE: begin
          if (w_wr_take) r_wr_st <= W_OWN;
        end
        W_OWN: begin
          if (w_wr_fin) begin
            r_wr_st  <= W_IDLE;
            r_wr_ptr <= ~r_wr_ptr;
          end
        end
        default: r_wr_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rd_st  <= R_IDLE;
      r_rd_ptr <= 1'b0;
    end else begin
      unique case (r_rd_st)
        R_IDLE: begin
          if (w_rd_take) r_rd_st <= R_OWN;
        end
        R_OWN: begin
          if (w_rd_fin) begin
            r_rd_st  <= R_IDLE;
            r_rd_ptr <= ~r_rd_ptr;
          end
        end
        default: r_rd_st <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_proto_err <= 1'b0;
    end else if (w_err) begin
      r_proto_err <= 1'b1;
    end
  end

  assign wr_grant  = (r_wr_st == W_OWN);
  assign rd_grant  = (r_rd_st == R_OWN);
  assign wr_bank   = r_wr_ptr;
  assign rd_bank   = r_rd_ptr;
  assign wr_addr_o = {r_wr_ptr, wr_addr_i};
  assign rd_addr_o = {r_rd_ptr, rd_addr_i};
  assign proto_err = r_proto_err;

  // FULL and DRAINING are the only encodings with the upper bit set.
  assign bank_full = {r_bank_st[1][1], r_bank_st[0][1]};

  a_excl : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (wr_grant && rd_grant) |-> (wr_bank != rd_bank));

endmodule

// File: tb/tb_act_buf_pingpong_ctrl.sv
// Directed bench for act_buf_pingpong_ctrl: grants, stalls,
// concurrent done, protocol errors and asynchronous reset.
module tb_act_buf_pingpong_ctrl;

  localparam int AWIDTH = 7;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              wr_req, wr_done, rd_req, rd_done;
  logic              wr_grant, wr_bank, rd_grant, rd_bank;
  logic [AWIDTH-1:0] wr_addr_i, rd_addr_i;
  logic [AWIDTH:0]   wr_addr_o, rd_addr_o;
  logic [1:0]        bank_full;
  logic              proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  act_buf_pingpong_ctrl #(.AWIDTH(AWIDTH)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .wr_req    (wr_req),
    .wr_grant  (wr_grant),
    .wr_bank   (wr_bank),
    .wr_done   (wr_done),
    .rd_req    (rd_req),
    .rd_grant  (rd_grant),
    .rd_bank   (rd_bank),
    .rd_done   (rd_done),
    .wr_addr_i (wr_addr_i),
    .wr_addr_o (wr_addr_o),
    .rd_addr_i (rd_addr_i),
    .rd_addr_o (rd_addr_o),
    .bank_full (bank_full),
    .proto_err (proto_err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    wr_req = 0; wr_done = 0; rd_req = 0; rd_done = 0;
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  task automatic fill();
    wr_req = 1; tick(); wr_req = 0;
    wr_done = 1; tick(); wr_done = 0;
  endtask

  initial begin
    wr_addr_i = '0;
    rd_addr_i = '0;
    do_reset();
    check("rst_wr_grant", wr_grant, 0);
    check("rst_rd_grant", rd_grant, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_proto_err", proto_err, 0);
    check("rst_wr_bank", wr_bank, 0);
    check("rst_rd_bank", rd_bank, 0);

    // Basic fill of bank 0
    wr_req = 1; tick(); wr_req = 0;
    check("basic_grant", wr_grant, 1);
    check("basic_bank", wr_bank, 0);
    wr_addr_i = 7'd5; #1;
    check("basic_addr", wr_addr_o, 8'h05);
    wr_done = 1; tick(); wr_done = 0;
    check("basic_full", bank_full, 2'b01);
    check("basic_grant_off", wr_grant, 0);
    check("basic_ptr", wr_bank, 1);

    // Ping-pong: read bank 0 while writing bank 1
    rd_req = 1; wr_req = 1; tick(); rd_req = 0; wr_req = 0;
    check("pp_rd_grant", rd_grant, 1);
    check("pp_rd_bank", rd_bank, 0);
    check("pp_wr_grant", wr_grant, 1);
    check("pp_wr_bank", wr_bank, 1);
    rd_addr_i = 7'd3; wr_addr_i = 7'd3; #1;
    check("pp_rd_addr", rd_addr_o, 8'h03);
    check("pp_wr_addr", wr_addr_o, 8'h83);
    check("pp_full", bank_full, 2'b01);
    wr_done = 1; rd_done = 1; tick(); wr_done = 0; rd_done = 0;
    check("pp_both_full", bank_full, 2'b10);
    check("pp_both_wg", wr_grant, 0);
    check("pp_both_rg", rd_grant, 0);
    check("pp_both_err", proto_err, 0);
    check("pp_rd_ptr", rd_bank, 1);

    // Full stall
    do_reset();
    fill();
    fill();
    check("fs_full", bank_full, 2'b11);
    wr_req = 1;
    tick(); tick(); tick();
    check("fs_stall", wr_grant, 0);
    check("fs_err", proto_err, 0);
    rd_req = 1; tick(); rd_req = 0;
    check("fs_rd_grant", rd_grant, 1);
    check("fs_stall2", wr_grant, 0);
    rd_done = 1; tick(); rd_done = 0;
    check("fs_no_bypass", wr_grant, 0);
    check("fs_freed", bank_full, 2'b10);
    tick();
    check("fs_grant", wr_grant, 1);
    check("fs_bank", wr_bank, 0);
    wr_req = 0;

    // Empty stall
    do_reset();
    rd_req = 1;
    for (int i = 0; i < 5; i++) tick();
    check("es_stall", rd_grant, 0);
    check("es_err", proto_err, 0);
    wr_req = 1; tick(); wr_req = 0;
    check("es_stall2", rd_grant, 0);
    wr_done = 1; tick(); wr_done = 0;
    check("es_no_bypass", rd_grant, 0);
    tick();
    check("es_grant", rd_grant, 1);
    check("es_bank", rd_bank, 0);
    check("es_draining", bank_full, 2'b01);
    rd_req = 0;

    // Protocol error while mid-read
    wr_done = 1; tick(); wr_done = 0;
    check("err_set", proto_err, 1);
    check("err_full", bank_full, 2'b01);
    check("err_wg", wr_grant, 0);
    tick();
    check("err_sticky", proto_err, 1);
    check("err_rg", rd_grant, 1);
    check("err_wbank", wr_bank, 1);

    // Asynchronous reset mid-read
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("ar_rg", rd_grant, 0);
    check("ar_wg", wr_grant, 0);
    check("ar_full", bank_full, 0);
    check("ar_err", proto_err, 0);
    check("ar_wbank", wr_bank, 0);
    check("ar_rbank", rd_bank, 0);
    tick();
    ap_rst_n = 1'b1;

    // First request after reset, then stray rd_done
    wr_req = 1; tick(); wr_req = 0;
    check("post_grant", wr_grant, 1);
    check("post_bank", wr_bank, 0);
    rd_done = 1; tick(); rd_done = 0;
    check("rd_err", proto_err, 1);
    check("rd_err_full", bank_full, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
